// File: rtl/sys_rst_pkg.sv
// Shared types, constants and sizing helper for the board reset sequencer.
package sys_rst_pkg;

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        REL_IC     = 3'd1,
        REL_PERIPH = 3'd2,
        REL_CORE   = 3'd3,
        RUN        = 3'd4
    } seq_state_e;

    // Synchronizers come out of reset at the level that requests reset.
    localparam logic LOCKED_RST_VAL = 1'b0;
    localparam logic EXT_RST_VAL    = 1'b0;
    localparam logic AUX_RST_VAL    = 1'b0;
    localparam logic DBG_RST_VAL    = 1'b1;

    function automatic int cnt_width(input int deb_cycles, input int stage_cycles);
        int max_cycles;
        max_cycles = (deb_cycles > stage_cycles) ? deb_cycles : stage_cycles;
        return $clog2(max_cycles + 32'sd1);
    endfunction

endpackage

// File: rtl/sys_rst_seq_if.sv
// Reset request inputs and staged reset outputs of the board reset sequencer.
interface sys_rst_seq_if;
    logic dcm_locked;
    logic ext_rst_n;
    logic aux_rst_n;
    logic dbg_sys_rst;
    logic interconnect_aresetn;
    logic peripheral_reset;
    logic peripheral_aresetn;
    logic core_rst_n;
    logic seq_done;

    modport master (
        output dcm_locked, ext_rst_n, aux_rst_n, dbg_sys_rst,
        input  interconnect_aresetn, peripheral_reset, peripheral_aresetn,
               core_rst_n, seq_done
    );

    modport slave (
        input  dcm_locked, ext_rst_n, aux_rst_n, dbg_sys_rst,
        output interconnect_aresetn, peripheral_reset, peripheral_aresetn,
               core_rst_n, seq_done
    );
endinterface

// File: rtl/sys_rst_filter.sv
// Input conditioning: multi-flop synchronizer with optional debounce filter.
module sys_rst_filter
    import sys_rst_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter bit   DEB_EN      = 1'b0,
    parameter logic RST_VAL     = 1'b0,
    parameter int   DEB_CYCLES  = 16,
    parameter int   CNT_W       = cnt_width(DEB_CYCLES, 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   filt_r;
    logic [CNT_W-1:0]       deb_cnt_r;

    // Synchronizer chain; the async input enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Debounce: flip only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r    <= RST_VAL;
            deb_cnt_r <= {CNT_W{1'b0}};
        end else if (sync_s != filt_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                filt_r    <= sync_s;
                deb_cnt_r <= {CNT_W{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + CNT_ONE;
            end
        end else begin
            deb_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign level = DEB_EN ? filt_r : sync_s;

endmodule

// File: rtl/sys_rst_seq.sv
// Board reset sequencer: releases interconnect, peripherals, then core once all
// reset requests are clear, and re-asserts every reset together on any fault.
module sys_rst_seq
    import sys_rst_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_CYCLES   = 16,
    parameter int STAGE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sys_rst_seq_if.slave bus
);

    localparam int               CNT_W      = cnt_width(DEB_CYCLES, STAGE_CYCLES);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic       locked_s;
    logic       ext_f_s;
    logic       aux_s;
    logic       dbg_s;
    logic       fault_s;
    logic       term_s;

    seq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ic_rstn_r;
    logic             periph_rst_r;
    logic             periph_rstn_r;
    logic             core_rstn_r;
    logic             done_r;

    sys_rst_filter #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_EN(1'b0), .RST_VAL(LOCKED_RST_VAL),
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
    ) u_locked (.clk(clk), .rst_n(rst_n), .async_in(bus.dcm_locked), .level(locked_s));

    // The button alone is bouncy; its filtered level starts out "pressed".
    sys_rst_filter #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_EN(1'b1), .RST_VAL(EXT_RST_VAL),
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
    ) u_ext (.clk(clk), .rst_n(rst_n), .async_in(bus.ext_rst_n), .level(ext_f_s));

    sys_rst_filter #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_EN(1'b0), .RST_VAL(AUX_RST_VAL),
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
    ) u_aux (.clk(clk), .rst_n(rst_n), .async_in(bus.aux_rst_n), .level(aux_s));

    sys_rst_filter #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_EN(1'b0), .RST_VAL(DBG_RST_VAL),
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
    ) u_dbg (.clk(clk), .rst_n(rst_n), .async_in(bus.dbg_sys_rst), .level(dbg_s));

    assign fault_s = ~locked_s | ~ext_f_s | ~aux_s | dbg_s;
    assign term_s  = (cnt_r == STAGE_LAST);

    // Release sequencer; fault wins over terminal count in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= HOLD;
            cnt_r         <= {CNT_W{1'b0}};
            ic_rstn_r     <= 1'b0;
            periph_rst_r  <= 1'b1;
            periph_rstn_r <= 1'b0;
            core_rstn_r   <= 1'b0;
            done_r        <= 1'b0;
        end else if (fault_s) begin
            state_r       <= HOLD;
            cnt_r         <= {CNT_W{1'b0}};
            ic_rstn_r     <= 1'b0;
            periph_rst_r  <= 1'b1;
            periph_rstn_r <= 1'b0;
            core_rstn_r   <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    state_r <= REL_IC;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                REL_IC: begin
                    if (term_s) begin
                        state_r   <= REL_PERIPH;
                        cnt_r     <= {CNT_W{1'b0}};
                        ic_rstn_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                REL_PERIPH: begin
                    if (term_s) begin
                        state_r       <= REL_CORE;
                        cnt_r         <= {CNT_W{1'b0}};
                        periph_rst_r  <= 1'b0;
                        periph_rstn_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                REL_CORE: begin
                    if (term_s) begin
                        state_r     <= RUN;
                        cnt_r       <= {CNT_W{1'b0}};
                        core_rstn_r <= 1'b1;
                        done_r      <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r       <= HOLD;
                    cnt_r         <= {CNT_W{1'b0}};
                    ic_rstn_r     <= 1'b0;
                    periph_rst_r  <= 1'b1;
                    periph_rstn_r <= 1'b0;
                    core_rstn_r   <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interconnect_aresetn = ic_rstn_r;
    assign bus.peripheral_reset     = periph_rst_r;
    assign bus.peripheral_aresetn   = periph_rstn_r;
    assign bus.core_rst_n           = core_rstn_r;
    assign bus.seq_done             = done_r;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Self-checking bench for sys_rst_seq: directed scenarios plus random request
// traffic, compared every cycle against a release-latency reference model.
module tb_sys_rst_seq;

    localparam int SS  = 2;
    localparam int DEB = 8;
    localparam int ST  = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   t0;

    sys_rst_seq_if bus ();

    sys_rst_seq #(.SYNC_STAGES(SS), .DEB_CYCLES(DEB), .STAGE_CYCLES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: delay lines, a run-length debouncer, and the count of
    // consecutive fault-free edges, from which each release follows directly.
    logic q_lock[$];
    logic q_ext[$];
    logic q_aux[$];
    logic q_dbg[$];
    logic m_ext_filt;
    int   m_run;
    int   m_k;

    task automatic model_reset();
        q_lock.delete(); q_ext.delete(); q_aux.delete(); q_dbg.delete();
        for (int i = 0; i < SS; i++) begin
            q_lock.push_back(1'b0);
            q_ext.push_back(1'b0);
            q_aux.push_back(1'b0);
            q_dbg.push_back(1'b1);
        end
        m_ext_filt = 1'b0;
        m_run      = 0;
        m_k        = 0;
    endtask

    task automatic model_step();
        logic fault;
        logic ext_sync;
        fault = ~q_lock[0] | ~m_ext_filt | ~q_aux[0] | q_dbg[0];
        if (fault) m_k = 0;
        else if (m_k < 1000) m_k++;
        ext_sync = q_ext[0];
        if (ext_sync != m_ext_filt) begin
            m_run++;
            if (m_run == DEB) begin
                m_ext_filt = ext_sync;
                m_run      = 0;
            end
        end else begin
            m_run = 0;
        end
        q_lock.push_back(bus.dcm_locked);  void'(q_lock.pop_front());
        q_ext.push_back(bus.ext_rst_n);    void'(q_ext.pop_front());
        q_aux.push_back(bus.aux_rst_n);    void'(q_aux.pop_front());
        q_dbg.push_back(bus.dbg_sys_rst);  void'(q_dbg.pop_front());
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic ic_e, pr_e, core_e;
        ic_e   = (m_k >= ST + 1);
        pr_e   = (m_k >= 2 * ST + 1);
        core_e = (m_k >= 3 * ST + 1);
        chk_bit({pfx, ".ic"},       bus.interconnect_aresetn, ic_e);
        chk_bit({pfx, ".prst"},     bus.peripheral_reset,     ~pr_e);
        chk_bit({pfx, ".prstn"},    bus.peripheral_aresetn,   pr_e);
        chk_bit({pfx, ".core"},     bus.core_rst_n,           core_e);
        chk_bit({pfx, ".done"},     bus.seq_done,             core_e);
        chk_bit({pfx, ".inv_pair"}, bus.peripheral_aresetn,   ~bus.peripheral_reset);
        chk_bit({pfx, ".inv_order"}, bus.core_rst_n & ~bus.peripheral_aresetn, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_outputs($sformatf("cyc%0d", cyc));
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return bus.interconnect_aresetn == 1'b1;
            1:       return bus.peripheral_aresetn == 1'b1;
            2:       return bus.core_rst_n == 1'b1;
            3:       return bus.interconnect_aresetn == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int budget);
        int n;
        n = 0;
        while (!cond(sel) && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Half-cycle rst_n pulse between clock edges; outputs must drop at once.
    task automatic async_pulse(input string pfx);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs(pfx);
        chk_bit({pfx, ".ic_now"}, bus.interconnect_aresetn, 1'b0);
        #4 rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        bus.dcm_locked  = 1'b0;
        bus.ext_rst_n   = 1'b1;
        bus.aux_rst_n   = 1'b1;
        bus.dbg_sys_rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        #1 rst_n = 1'b1;

        // Power-up: lock arrives at cycle 20.
        repeat (19) tick();
        bus.dcm_locked = 1'b1;
        t0 = cyc;
        wait_cond(0, 40);
        chk_int("pwr_ic_lat", cyc - t0, SS + ST + 1);
        wait_cond(1, 40);
        chk_int("pwr_periph_lat", cyc - t0, SS + 2 * ST + 1);
        wait_cond(2, 40);
        chk_int("pwr_core_lat", cyc - t0, SS + 3 * ST + 1);
        chk_bit("pwr_done", bus.seq_done, 1'b1);

        // Short button glitch is filtered out.
        bus.ext_rst_n = 1'b0;
        repeat (5) tick();
        bus.ext_rst_n = 1'b1;
        repeat (20) tick();
        chk_bit("glitch_core", bus.core_rst_n, 1'b1);

        // Long press asserts, then release restarts the sequence.
        bus.ext_rst_n = 1'b0;
        t0 = cyc;
        wait_cond(3, 40);
        chk_int("btn_assert_lat", cyc - t0, SS + DEB + 1);
        while (cyc - t0 < 12) tick();
        bus.ext_rst_n = 1'b1;
        t0 = cyc;
        wait_cond(0, 60);
        chk_int("btn_rerelease_lat", cyc - t0, SS + DEB + ST + 1);

        // Lock loss during REL_PERIPH.
        tick();
        bus.dcm_locked = 1'b0;
        t0 = cyc;
        wait_cond(3, 20);
        chk_int("lock_loss_lat", cyc - t0, SS + 1);
        bus.dcm_locked = 1'b1;
        t0 = cyc;
        wait_cond(0, 40);
        chk_int("lock_back_ic_lat", cyc - t0, SS + ST + 1);
        wait_cond(1, 40);
        chk_int("lock_back_periph_lat", cyc - t0, SS + 2 * ST + 1);

        // Debug pulse lands on the REL_CORE terminal count.
        tick();
        bus.dbg_sys_rst = 1'b1;
        tick();
        bus.dbg_sys_rst = 1'b0;
        tick();
        tick();
        chk_bit("simul_core", bus.core_rst_n, 1'b0);
        chk_bit("simul_hold", bus.interconnect_aresetn, 1'b0);

        // Async reset during REL_IC, then again in RUN.
        tick();
        tick();
        async_pulse("arst_ic");
        t0 = cyc;
        wait_cond(2, 60);
        chk_int("arst_ic_core_lat", cyc - t0, SS + DEB + 3 * ST + 1);
        tick();
        async_pulse("arst_run");
        t0 = cyc;
        wait_cond(2, 60);
        chk_int("arst_run_core_lat", cyc - t0, SS + DEB + 3 * ST + 1);

        // Random request traffic against the model.
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            bus.dcm_locked  = ($urandom_range(0, 7) != 0);
            bus.ext_rst_n   = ($urandom_range(0, 5) != 0);
            bus.aux_rst_n   = ($urandom_range(0, 7) != 0);
            bus.dbg_sys_rst = ($urandom_range(0, 9) == 0);
            len = $urandom_range(1, 40);
            repeat (len) tick();
            if ($urandom_range(0, 19) == 0) async_pulse($sformatf("rnd_arst%0d", seg));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
